pc_sequencer: RTL and testbench

- Parametrised program-counter sequencer for the 8-bit core and its wider derivatives; the fetch stage consumes its pc output.
- Beyond plain increment it supports:
  - absolute jump
  - signed PC-relative branch
  - subroutine call/return through an internal return-address stack (RAS)
  - sticky fault detection with halt
- Sits between the control unit, which issues op/target/offset, and instruction memory, which is addressed by pc.

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/return_stack.sv | 56 +++++
 rtl/pc_sequencer.sv | 110 +++++++++++
 tb/tb_pc_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter sequencer: op codes, fault codes,
// sequencer state and the RAS count-width helper.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HOLD   = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    FC_NONE = 2'd0,
    FC_OVF  = 2'd1,
    FC_UNF  = 2'd2,
    FC_ILL  = 2'd3
  } fault_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } seq_state_e;

  // Width needed to count 0..depth valid return-stack entries.
  function automatic int cntWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit <-> sequencer bundle: op request in, pc and fault status out.
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int PC_WIDTH     = 8,
  parameter int OFFSET_WIDTH = 8,
  parameter int RAS_DEPTH    = 4
);

  logic                           enable;
  logic [2:0]                     op;
  logic [PC_WIDTH-1:0]            target;
  logic [OFFSET_WIDTH-1:0]        offset;
  logic [PC_WIDTH-1:0]            pc;
  logic [cntWidth(RAS_DEPTH)-1:0] ras_count;
  logic                           fault;
  logic [1:0]                     fault_code;

  modport master (
    output enable, op, target, offset,
    input  pc, ras_count, fault, fault_code
  );

  modport slave (
    input  enable, op, target, offset,
    output pc, ras_count, fault, fault_code
  );

endinterface

// File: rtl/return_stack.sv
// Return-address LIFO. Push/pop are ignored when full/empty; dout is the
// current top entry and is meaningless while the stack is empty.
module return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [cntWidth(DEPTH)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = cntWidth(DEPTH);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] w_wrIdx;
  logic [IDX_W-1:0] w_topIdx;
  logic             w_doPush;
  logic             w_doPop;

  assign full     = (r_count == CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_doPush = push & ~full;
  assign w_doPop  = pop & ~empty;
  assign w_wrIdx  = IDX_W'(r_count);
  assign w_topIdx = IDX_W'(r_count - CNT_W'(1));
  assign dout     = r_mem[w_topIdx];
  assign count    = r_count;

  // Entries need no reset: only slots below r_count are ever read.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[w_wrIdx] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_doPush) begin
      r_count <= r_count + CNT_W'(1);
    end else if (w_doPop) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: inc/jump/branch/call/return with a return-address
// stack, and a sticky fault state that freezes everything until reset.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          PC_WIDTH     = 8,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int          RAS_DEPTH    = 4,
  parameter int          OFFSET_WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);

  localparam int CNT_W = cntWidth(RAS_DEPTH);
  localparam int SUM_W = (PC_WIDTH > OFFSET_WIDTH) ? PC_WIDTH : OFFSET_WIDTH;
  localparam logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_VECTOR);

  seq_state_e          r_state;
  seq_state_e          w_nextState;
  fault_e              r_faultCode;
  fault_e              w_nextCode;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_nextPc;
  logic [PC_WIDTH-1:0] w_incPc;
  logic [PC_WIDTH-1:0] w_branchPc;
  logic [PC_WIDTH-1:0] w_top;
  logic [CNT_W-1:0]    w_count;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;

  assign w_incPc    = r_pc + PC_WIDTH'(1);
  // Sum at the wider of the two widths so the offset sign-extends, then wrap.
  assign w_branchPc = PC_WIDTH'(SUM_W'(r_pc) + SUM_W'($signed(bus.offset)));

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_incPc),
    .dout  (w_top),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_faultCode <= FC_NONE;
      r_pc        <= RESET_PC;
    end else begin
      r_state     <= w_nextState;
      r_faultCode <= w_nextCode;
      r_pc        <= w_nextPc;
    end
  end

  // Once faulted, or while disabled, nothing is decoded and no new fault can arise.
  always_comb begin
    w_nextState = r_state;
    w_nextCode  = r_faultCode;
    w_nextPc    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if (r_state == ST_RUN && bus.enable) begin
      case (op_e'(bus.op))
        OP_INC:    w_nextPc = w_incPc;
        OP_JUMP:   w_nextPc = bus.target;
        OP_BRANCH: w_nextPc = w_branchPc;
        OP_CALL: begin
          if (w_full) begin
            w_nextState = ST_FAULT;
            w_nextCode  = FC_OVF;
          end else begin
            w_push   = 1'b1;
            w_nextPc = bus.target;
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_nextState = ST_FAULT;
            w_nextCode  = FC_UNF;
          end else begin
            w_pop    = 1'b1;
            w_nextPc = w_top;
          end
        end
        OP_HOLD: ;
        default: begin
          w_nextState = ST_FAULT;
          w_nextCode  = FC_ILL;
        end
      endcase
    end
  end

  assign bus.pc         = r_pc;
  assign bus.ras_count  = w_count;
  assign bus.fault      = (r_state == ST_FAULT);
  assign bus.fault_code = r_faultCode;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: an 8-bit and a 12-bit instance, each shadowed by an
// arithmetic model checked every cycle, plus hand-computed literal expectations.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic reset8;
  logic reset12;
  bit   checkEn = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  // Model state, index 0 = 8-bit instance, index 1 = 12-bit instance.
  int mPc   [2] = '{0, 'h100};
  int mCnt  [2] = '{0, 0};
  int mCode [2] = '{0, 0};
  int mFault[2] = '{0, 0};
  int mStk  [2][4];

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_WIDTH(8),  .OFFSET_WIDTH(8), .RAS_DEPTH(4)) bus8();
  pc_sequencer_if #(.PC_WIDTH(12), .OFFSET_WIDTH(8), .RAS_DEPTH(4)) bus12();

  pc_sequencer #(.PC_WIDTH(8), .RESET_VECTOR(0), .RAS_DEPTH(4), .OFFSET_WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset8),
    .bus   (bus8)
  );

  pc_sequencer #(.PC_WIDTH(12), .RESET_VECTOR(32'h100), .RAS_DEPTH(4), .OFFSET_WIDTH(8)) dut12 (
    .clk   (clk),
    .reset (reset12),
    .bus   (bus12)
  );

  task automatic modelReset(input int d);
    mPc[d]    = (d == 0) ? 0 : 'h100;
    mCnt[d]   = 0;
    mCode[d]  = 0;
    mFault[d] = 0;
  endtask

  task automatic modelFault(input int d, input int code);
    mFault[d] = 1;
    mCode[d]  = code;
  endtask

  task automatic modelStep(input int d, input int en, input int op, input int tgt, input int off);
    int mask;
    int so;
    mask = (d == 0) ? 'hFF : 'hFFF;
    if (mFault[d] != 0 || en == 0) return;
    case (op)
      0: mPc[d] = (mPc[d] + 1) & mask;
      1: mPc[d] = tgt & mask;
      2: begin
        so = off & 'hFF;
        if (so > 127) so = so - 256;
        mPc[d] = (mPc[d] + so) & mask;
      end
      3: begin
        if (mCnt[d] == 4) modelFault(d, 1);
        else begin
          mStk[d][mCnt[d]] = (mPc[d] + 1) & mask;
          mCnt[d] = mCnt[d] + 1;
          mPc[d]  = tgt & mask;
        end
      end
      4: begin
        if (mCnt[d] == 0) modelFault(d, 2);
        else begin
          mCnt[d] = mCnt[d] - 1;
          mPc[d]  = mStk[d][mCnt[d]];
        end
      end
      5: ;
      default: modelFault(d, 3);
    endcase
  endtask

  always @(posedge clk or posedge reset8) begin
    if (reset8) modelReset(0);
    else modelStep(0, int'(bus8.enable), int'(bus8.op), int'(bus8.target), int'(bus8.offset));
  end

  always @(posedge clk or posedge reset12) begin
    if (reset12) modelReset(1);
    else modelStep(1, int'(bus12.enable), int'(bus12.op), int'(bus12.target), int'(bus12.offset));
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc8_pc",     int'(bus8.pc),          mPc[0]);
      checkOutput("cyc8_count",  int'(bus8.ras_count),   mCnt[0]);
      checkOutput("cyc8_fault",  int'(bus8.fault),       mFault[0]);
      checkOutput("cyc8_code",   int'(bus8.fault_code),  mCode[0]);
      checkOutput("cyc12_pc",    int'(bus12.pc),         mPc[1]);
      checkOutput("cyc12_count", int'(bus12.ras_count),  mCnt[1]);
      checkOutput("cyc12_fault", int'(bus12.fault),      mFault[1]);
      checkOutput("cyc12_code",  int'(bus12.fault_code), mCode[1]);
    end
  end

  // Literal pc expectation applied to both the DUT and the model.
  task automatic expectPc(input string name, input int d, input int lit);
    checkOutput(name, (d == 0) ? int'(bus8.pc) : int'(bus12.pc), lit);
    checkOutput({name, "_model"}, mPc[d], lit);
  endtask

  task automatic expectStatus(input string name, input int d, input int cnt, input int flt, input int code);
    if (d == 0) begin
      checkOutput({name, "_count"}, int'(bus8.ras_count), cnt);
      checkOutput({name, "_fault"}, int'(bus8.fault), flt);
      checkOutput({name, "_code"},  int'(bus8.fault_code), code);
    end else begin
      checkOutput({name, "_count"}, int'(bus12.ras_count), cnt);
      checkOutput({name, "_fault"}, int'(bus12.fault), flt);
      checkOutput({name, "_code"},  int'(bus12.fault_code), code);
    end
    checkOutput({name, "_mcode"}, mCode[d], code);
  endtask

  task automatic applyStimulus(input int d, input bit en, input logic [2:0] op, input int tgt, input int off);
    if (d == 0) begin
      bus8.enable = en;
      bus8.op     = op;
      bus8.target = 8'(tgt);
      bus8.offset = 8'(off);
    end else begin
      bus12.enable = en;
      bus12.op     = op;
      bus12.target = 12'(tgt);
      bus12.offset = 8'(off);
    end
    @(posedge clk);
    #1;
    if (d == 0) bus8.enable = 1'b0;
    else bus12.enable = 1'b0;
  endtask

  task automatic doReset(input int d);
    if (d == 0) reset8 = 1'b1;
    else reset12 = 1'b1;
    @(posedge clk);
    #1;
    if (d == 0) reset8 = 1'b0;
    else reset12 = 1'b0;
  endtask

  initial begin
    reset8  = 1'b1;
    reset12 = 1'b1;
    bus8.enable  = 1'b0; bus8.op  = 3'd0; bus8.target  = '0; bus8.offset  = '0;
    bus12.enable = 1'b0; bus12.op = 3'd0; bus12.target = '0; bus12.offset = '0;
    repeat (2) @(posedge clk);
    #1;
    reset8  = 1'b0;
    reset12 = 1'b0;
    checkEn = 1'b1;

    expectPc("rst8_pc", 0, 'h00);
    expectStatus("rst8", 0, 0, 0, 0);
    expectPc("rst12_pc", 1, 'h100);

    // Increment run, then asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, OP_INC, 0, 0);
    expectPc("inc5_pc", 0, 'h05);
    #2;
    reset8 = 1'b1;
    #1;
    checkOutput("async_rst_pc", int'(bus8.pc), 'h00);
    @(posedge clk);
    #1;
    reset8 = 1'b0;

    // Wrap-around, backward branch, disabled jump.
    applyStimulus(0, 1'b1, OP_JUMP, 'hFE, 0);
    applyStimulus(0, 1'b1, OP_INC, 0, 0);
    expectPc("inc_ff", 0, 'hFF);
    applyStimulus(0, 1'b1, OP_INC, 0, 0);
    expectPc("inc_wrap", 0, 'h00);
    applyStimulus(0, 1'b1, OP_INC, 0, 0);
    applyStimulus(0, 1'b1, OP_BRANCH, 0, 'hFC);
    expectPc("branch_back", 0, 'hFD);
    applyStimulus(0, 1'b0, OP_JUMP, 'h33, 0);
    expectPc("disabled_jump", 0, 'hFD);

    // Nested call / return.
    applyStimulus(0, 1'b1, OP_JUMP, 'h10, 0);
    applyStimulus(0, 1'b1, OP_CALL, 'h80, 0);
    expectPc("call1_pc", 0, 'h80);
    expectStatus("call1", 0, 1, 0, 0);
    applyStimulus(0, 1'b1, OP_CALL, 'hA0, 0);
    expectStatus("call2", 0, 2, 0, 0);
    applyStimulus(0, 1'b1, OP_RET, 0, 0);
    expectPc("ret1_pc", 0, 'h81);
    applyStimulus(0, 1'b1, OP_RET, 0, 0);
    expectPc("ret2_pc", 0, 'h11);
    expectStatus("ret2", 0, 0, 0, 0);

    // Stack overflow on the fifth call; faulted state then ignores everything.
    applyStimulus(0, 1'b1, OP_JUMP, 'h20, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, OP_CALL, 'h30 + 'h10 * i, 0);
    expectPc("call4_pc", 0, 'h60);
    applyStimulus(0, 1'b1, OP_CALL, 'h70, 0);
    expectPc("ovf_pc", 0, 'h60);
    expectStatus("ovf", 0, 4, 1, 1);
    applyStimulus(0, 1'b1, OP_INC, 0, 0);
    applyStimulus(0, 1'b1, OP_RET, 0, 0);
    expectPc("ovf_frozen_pc", 0, 'h60);
    expectStatus("ovf_frozen", 0, 4, 1, 1);
    doReset(0);
    expectStatus("ovf_cleared", 0, 0, 0, 0);

    // Reset discards stack entries, so the following return underflows.
    applyStimulus(0, 1'b1, OP_CALL, 'h90, 0);
    doReset(0);
    applyStimulus(0, 1'b1, OP_RET, 0, 0);
    expectPc("unf_pc", 0, 'h00);
    expectStatus("unf", 0, 0, 1, 2);
    applyStimulus(0, 1'b1, 3'd7, 0, 0);
    expectStatus("unf_keep", 0, 0, 1, 2);
    doReset(0);

    // Hold, self-loop and forward branch; illegal op ignored while disabled.
    applyStimulus(0, 1'b1, OP_JUMP, 'h42, 0);
    applyStimulus(0, 1'b1, OP_HOLD, 'h99, 'h10);
    expectPc("hold_pc", 0, 'h42);
    applyStimulus(0, 1'b1, OP_BRANCH, 0, 'h00);
    expectPc("self_loop", 0, 'h42);
    applyStimulus(0, 1'b1, OP_BRANCH, 0, 'h05);
    expectPc("branch_fwd", 0, 'h47);
    applyStimulus(0, 1'b0, 3'd6, 0, 0);
    expectStatus("ill_disabled", 0, 0, 0, 0);
    applyStimulus(0, 1'b1, 3'd6, 0, 0);
    expectPc("ill_pc", 0, 'h47);
    expectStatus("ill", 0, 0, 1, 3);
    applyStimulus(0, 1'b1, OP_RET, 0, 0);
    applyStimulus(0, 1'b1, OP_CALL, 'h55, 0);
    expectStatus("ill_keep", 0, 0, 1, 3);
    expectPc("ill_keep_pc", 0, 'h47);

    // Wide instance: wrap at 12 bits and branches around zero.
    applyStimulus(1, 1'b1, OP_JUMP, 'hFFF, 0);
    expectPc("w_jump", 1, 'hFFF);
    applyStimulus(1, 1'b1, OP_INC, 0, 0);
    expectPc("w_wrap", 1, 'h000);
    applyStimulus(1, 1'b1, OP_BRANCH, 0, 'h7F);
    expectPc("w_branch_fwd", 1, 'h07F);
    applyStimulus(1, 1'b1, OP_BRANCH, 0, 'h80);
    expectPc("w_branch_back", 1, 'hFFF);
    applyStimulus(1, 1'b1, OP_CALL, 'h200, 0);
    expectStatus("w_call", 1, 1, 0, 0);
    applyStimulus(1, 1'b1, OP_RET, 0, 0);
    expectPc("w_ret", 1, 'h000);

    repeat (2) @(posedge clk);
    #1;
    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
